systolic_act_skewer: RTL and testbench

Input stage for the systolic PE array's left edge. It accepts one activation column per valid/ready beat, carrying one element per array row, and applies the wavefront skew the array needs: row i is delayed by i cycles relative to row 0. Cycles with no input beat are driven as zeros, so the array's free-running PEs accumulate nothing for them. At end of tile it flushes the skew pipeline, then reports completion and beat count to the tile controller.

---
 rtl/systolic_act_skewer.sv | 116 +++++++++++
 tb/tb_systolic_act_skewer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_act_skewer.sv
// Left-edge activation skewer: row r sees each accepted column r cycles after row 0.
// After the last column of a tile the input is closed while the skew pipeline drains.
module systolic_act_skewer #(
  parameter int PE_ARRAY_H    = 64,
  parameter int IN_DATA_WIDTH = 8,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      s_vld,
  output logic                                      s_rdy,
  input  logic [PE_ARRAY_H-1:0][IN_DATA_WIDTH-1:0]  s_data,
  input  logic                                      s_last,
  output logic [PE_ARRAY_H-1:0][IN_DATA_WIDTH-1:0]  o_left_data,
  output logic [PE_ARRAY_H-1:0]                     o_left_vld,
  output logic                                      o_tile_done,
  output logic [LEN_WIDTH-1:0]                      o_tile_len
);

  localparam int FCW = (PE_ARRAY_H > 1) ? $clog2(PE_ARRAY_H) : 1;
  localparam logic [FCW-1:0] FLUSH_INIT = FCW'(PE_ARRAY_H - 1);

  localparam logic [0:0] ST_STREAM = 1'b0;
  localparam logic [0:0] ST_FLUSH  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] pend_q, pend_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [FCW-1:0]       flush_q, flush_d;
  logic                 done_q, done_d;
  logic                 hs;
  logic [LEN_WIDTH-1:0] cnt_inc;

  // Ready depends on state only, so a source may legally wait on it.
  assign s_rdy   = rst && (state_q == ST_STREAM);
  assign hs      = s_vld && s_rdy;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    len_d   = len_q;
    flush_d = flush_q;
    done_d  = 1'b0;
    case (state_q)
      ST_STREAM: begin
        if (hs) begin
          if (s_last) begin
            pend_d  = cnt_inc;
            cnt_d   = '0;
            flush_d = FLUSH_INIT;
            state_d = ST_FLUSH;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        if (flush_q == '0) begin
          state_d = ST_STREAM;
          done_d  = 1'b1;
          len_d   = pend_q;
        end else begin
          flush_d = flush_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_STREAM;
      cnt_q   <= '0;
      pend_q  <= '0;
      len_q   <= '0;
      flush_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      len_q   <= len_d;
      flush_q <= flush_d;
      done_q  <= done_d;
    end
  end

  assign o_tile_done = done_q;
  assign o_tile_len  = len_q;

  // Row r: r+1 stages, no stall; data is zeroed on entry for bubbles so it stays 0 whenever vld is 0.
  for (genvar r = 0; r < PE_ARRAY_H; r++) begin : g_row
    logic [r:0]                    vld_pipe;
    logic [r:0][IN_DATA_WIDTH-1:0] dat_pipe;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_pipe <= '0;
        dat_pipe <= '0;
      end else begin
        vld_pipe[0] <= hs;
        dat_pipe[0] <= hs ? s_data[r] : '0;
        for (int k = 1; k <= r; k++) begin
          vld_pipe[k] <= vld_pipe[k-1];
          dat_pipe[k] <= dat_pipe[k-1];
        end
      end
    end

    assign o_left_vld[r]  = vld_pipe[r];
    assign o_left_data[r] = dat_pipe[r];
  end

endmodule

// File: tb/tb_systolic_act_skewer.sv
// Bench: random + directed traffic on a 4-row skewer against an edge-indexed reference,
// and a vector table on a 1-row skewer.
module tb_systolic_act_skewer;
  localparam int H_A  = 4;
  localparam int W    = 8;
  localparam int LW_A = 4;
  localparam int AMAX = (1 << LW_A) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  function automatic void chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endfunction

  // ---------------- DUT A: 4 rows, 4-bit length ----------------
  logic                   rst_a = 1'b0;
  logic                   a_vld = 1'b0, a_last = 1'b0, a_rdy;
  logic [H_A-1:0][W-1:0]  a_data = '0, a_left_data;
  logic [H_A-1:0]         a_left_vld;
  logic                   a_done;
  logic [LW_A-1:0]        a_len;

  systolic_act_skewer #(.PE_ARRAY_H(H_A), .IN_DATA_WIDTH(W), .LEN_WIDTH(LW_A)) u_a (
    .clk(clk), .rst(rst_a), .s_vld(a_vld), .s_rdy(a_rdy), .s_data(a_data), .s_last(a_last),
    .o_left_data(a_left_data), .o_left_vld(a_left_vld), .o_tile_done(a_done), .o_tile_len(a_len));

  // ---------------- DUT B: 1 row, 16-bit length ----------------
  logic            b_rst = 1'b0;
  logic            b_vld = 1'b0, b_last = 1'b0, b_rdy;
  logic [0:0][W-1:0] b_data = '0, b_left_data;
  logic [0:0]      b_left_vld;
  logic            b_done;
  logic [15:0]     b_len;
  bit              b_fin = 1'b0;

  systolic_act_skewer #(.PE_ARRAY_H(1), .IN_DATA_WIDTH(W), .LEN_WIDTH(16)) u_b (
    .clk(clk), .rst(b_rst), .s_vld(b_vld), .s_rdy(b_rdy), .s_data(b_data), .s_last(b_last),
    .o_left_data(b_left_data), .o_left_vld(b_left_vld), .o_tile_done(b_done), .o_tile_len(b_len));

  // ---------------- reference for A, indexed by clock-edge number ----------------
  // Beat captured at edge e shows on row i after edge e+i; a last beat at edge t
  // closes input until edge t+H and pulses done after edge t+H.
  int e = 0, base = 1, rdy_edge = 0, done_edge = -1;
  int cnt_m = 0, pend_m = 0, len_m = 0;
  bit hv [int];
  logic [H_A-1:0][W-1:0] hd [int];

  always @(posedge clk) begin : model
    bit hs;
    int idx;
    bit expv;
    int expd;
    e++;
    hs = a_vld && rst_a && (e - 1 >= rdy_edge);
    if (!rst_a) begin
      base = e + 1; cnt_m = 0; rdy_edge = 0; done_edge = -1; len_m = 0;
    end else begin
      hv[e] = hs;
      hd[e] = a_data;
      if (hs) begin
        cnt_m = (cnt_m < AMAX) ? cnt_m + 1 : AMAX;
        if (a_last) begin
          pend_m = cnt_m; cnt_m = 0; rdy_edge = e + H_A; done_edge = e + H_A;
        end
      end
      if (e == done_edge) len_m = pend_m;
    end
    #1;
    for (int i = 0; i < H_A; i++) begin
      idx  = e - i;
      expv = (idx >= base) && hv.exists(idx) && hv[idx];
      expd = expv ? int'(hd[idx][i]) : 0;
      chk($sformatf("a_vld_row%0d", i), int'(a_left_vld[i]), int'(expv));
      chk($sformatf("a_data_row%0d", i), int'(a_left_data[i]), expd);
    end
    chk("a_done", int'(a_done), int'(rst_a && e == done_edge));
    chk("a_len", int'(a_len), len_m);
    chk("a_rdy", int'(a_rdy), int'(rst_a && e >= rdy_edge));
  end

  task automatic drive(input bit v, input bit l, input logic [H_A-1:0][W-1:0] d);
    @(negedge clk);
    a_vld = v; a_last = l; a_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0);
  endtask

  function automatic logic [H_A-1:0][W-1:0] col(input int k);
    logic [H_A-1:0][W-1:0] d;
    for (int i = 0; i < H_A; i++) d[i] = W'(16 * k + i);
    return d;
  endfunction

  // ---------------- B: vector table ----------------
  typedef struct {
    bit r, v, l;
    logic [7:0] d;
    bit erdy, evld;
    logic [7:0] edat;
    bit edone;
    int elen;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, bit l, logic [7:0] d, bit erdy, bit evld,
                              logic [7:0] edat, bit edone, int elen);
    vec_t x;
    x.r = r; x.v = v; x.l = l; x.d = d; x.erdy = erdy; x.evld = evld;
    x.edat = edat; x.edone = edone; x.elen = elen;
    return x;
  endfunction

  initial begin : tbl
    vec_t tv[15];
    tv[0]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    tv[1]  = mk(0, 1, 1, 8'h99, 0, 0, 8'h00, 0, 0);
    tv[2]  = mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    tv[3]  = mk(1, 1, 1, 8'hA5, 1, 1, 8'hA5, 0, 0);  // 1-beat tile
    tv[4]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1);  // done after t+1
    tv[5]  = mk(1, 1, 0, 8'h3C, 1, 1, 8'h3C, 0, 1);
    tv[6]  = mk(1, 1, 1, 8'h7E, 1, 1, 8'h7E, 0, 1);
    tv[7]  = mk(1, 1, 0, 8'h11, 0, 0, 8'h00, 1, 2);  // held during flush: dropped
    tv[8]  = mk(1, 1, 1, 8'h11, 1, 1, 8'h11, 0, 2);  // accepted in the done cycle
    tv[9]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1);
    tv[10] = mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 1);
    tv[11] = mk(1, 1, 0, 8'h22, 1, 1, 8'h22, 0, 1);
    tv[12] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);  // reset drops the open tile
    tv[13] = mk(1, 1, 1, 8'h33, 1, 1, 8'h33, 0, 0);
    tv[14] = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      b_rst = tv[k].r; b_vld = tv[k].v; b_last = tv[k].l; b_data[0] = tv[k].d;
      #1;
      chk($sformatf("b_rdy[%0d]", k), int'(b_rdy), int'(tv[k].erdy));
      @(posedge clk);
      #1;
      chk($sformatf("b_vld[%0d]", k), int'(b_left_vld[0]), int'(tv[k].evld));
      chk($sformatf("b_data[%0d]", k), int'(b_left_data[0]), int'(tv[k].edat));
      chk($sformatf("b_done[%0d]", k), int'(b_done), int'(tv[k].edone));
      chk($sformatf("b_len[%0d]", k), int'(b_len), tv[k].elen);
    end
    b_fin = 1'b1;
  end

  // ---------------- A: directed + random sequences ----------------
  initial begin : main
    int n;
    bit acc;
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    #1 chk("rdy_after_release", int'(a_rdy), 1);
    idle(4);

    // skew alignment, 3 back-to-back beats
    for (int k = 1; k <= 3; k++) drive(1'b1, k == 3, col(k));
    drive(1'b0, 1'b0, '0);
    n = 0;
    for (int j = 0; j < 8; j++) begin
      #1 if (!a_rdy) n++;
      @(negedge clk);
    end
    chk("skew_rdy_low_cycles", n, H_A);
    chk("skew_len", int'(a_len), 3);

    // bubbles
    drive(1'b1, 1'b0, col(5));
    idle(2);
    drive(1'b1, 1'b1, col(6));
    idle(8);
    chk("bubble_len", int'(a_len), 2);

    // held input through FLUSH, then a second tile starting in the done cycle
    drive(1'b1, 1'b1, col(7));
    @(negedge clk);
    a_vld = 1'b1; a_last = 1'b0; a_data = col(8);
    acc = 1'b0; n = 0;
    for (int j = 0; j < 10 && !acc; j++) begin
      #1;
      if (a_rdy) begin
        acc = 1'b1;
        chk("held_done_in_accept_cycle", int'(a_done), 1);
      end else n++;
      @(negedge clk);
    end
    chk("held_accepted", int'(acc), 1);
    chk("held_wait_cycles", n, H_A);
    a_vld = 1'b1; a_last = 1'b1; a_data = col(9);
    idle(8);
    chk("second_tile_len", int'(a_len), 2);

    // random traffic
    for (int j = 0; j < 300; j++)
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, {$urandom, $urandom} & 32'hFFFF_FFFF);
    idle(10);

    // reset during FLUSH
    drive(1'b1, 1'b0, col(10));
    drive(1'b1, 1'b1, col(11));
    idle(2);
    rst_a = 1'b0;
    #1;
    chk("midrst_vld", int'(a_left_vld), 0);
    chk("midrst_data", int'(a_left_data), 0);
    chk("midrst_len", int'(a_len), 0);
    idle(2);
    rst_a = 1'b1;
    for (int k = 12; k <= 14; k++) drive(1'b1, k == 14, col(k));
    idle(8);
    chk("post_rst_len", int'(a_len), 3);

    // saturation: 20 beats on a 4-bit counter
    for (int k = 1; k <= 20; k++) drive(1'b1, k == 20, col(k));
    idle(8);
    chk("sat_len", int'(a_len), AMAX);

    n = 0;
    while (!b_fin && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("table_finished", int'(b_fin), 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
